// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / load-store) arbiter in front of a single-port synchronous memory.
// Define ARB_FAIR_EN to bound how many LS grants in a row may pass a waiting fetch.
module mem_port_arbiter #(
    parameter int WIDTH      = 32,
    parameter int STREAK_MAX = 4
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic             if_ready,
    output logic [WIDTH-1:0] if_rdata,
    input  logic             ls_req,
    input  logic             ls_we,
    input  logic [WIDTH-1:0] ls_addr,
    input  logic [WIDTH-1:0] ls_wdata,
    output logic             ls_ready,
    output logic [WIDTH-1:0] ls_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             owner_ls;
    logic             lat_we;
    logic [WIDTH-1:0] lat_addr;
    logic [WIDTH-1:0] lat_wdata;
    logic [WIDTH-1:0] if_hold;
    logic [WIDTH-1:0] ls_hold;
    logic             if_turn;
    logic             grant_ls;
    logic             grant_if;

`ifdef ARB_FAIR_EN
    localparam int CW = $clog2(STREAK_MAX + 1);

    logic [CW-1:0] streak;

    assign if_turn = if_req && (streak == CW'(STREAK_MAX));

    // Counts LS wins that bypassed a waiting fetch; saturates at STREAK_MAX.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            streak <= '0;
        end else if (state == IDLE) begin
            if (!if_req || grant_if) begin
                streak <= '0;
            end else if (grant_ls && streak != CW'(STREAK_MAX)) begin
                streak <= streak + 1'b1;
            end
        end
    end
`else
    logic [31:0] unused_streak_max;

    assign unused_streak_max = 32'(STREAK_MAX);
    assign if_turn           = 1'b0;
`endif

    assign grant_ls = ls_req && !if_turn;
    assign grant_if = if_req && !grant_ls;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        unique case (state)
            IDLE:    state_nxt = (ls_req || if_req) ? ACCESS : IDLE;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Winner's request is captured once and held through ACCESS and RESP.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            owner_ls  <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == IDLE && (grant_ls || grant_if)) begin
            owner_ls  <= grant_ls;
            lat_we    <= grant_ls && ls_we;
            lat_addr  <= grant_ls ? ls_addr : if_addr;
            lat_wdata <= grant_ls ? ls_wdata : '0;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            if_hold <= '0;
            ls_hold <= '0;
        end else if (state == RESP) begin
            if (owner_ls) begin
                ls_hold <= mem_rdata;
            end else begin
                if_hold <= mem_rdata;
            end
        end
    end

    always_comb begin
        mem_en    = (state == ACCESS);
        mem_we    = (state == ACCESS) && lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        if_ready  = (state == RESP) && !owner_ls;
        ls_ready  = (state == RESP) && owner_ls;
        if_rdata  = if_ready ? mem_rdata : if_hold;
        ls_rdata  = ls_ready ? mem_rdata : ls_hold;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous memory model.
// Fairness expectations follow whether ARB_FAIR_EN is defined.
module tb_mem_port_arbiter;

    localparam int W = 32;

    logic         CLOCK = 1'b0;
    logic         RESET = 1'b1;
    logic         if_req = 1'b0;
    logic [W-1:0] if_addr = '0;
    logic         if_ready;
    logic [W-1:0] if_rdata;
    logic         ls_req = 1'b0;
    logic         ls_we = 1'b0;
    logic [W-1:0] ls_addr = '0;
    logic [W-1:0] ls_wdata = '0;
    logic         ls_ready;
    logic [W-1:0] ls_rdata;
    logic         mem_en;
    logic         mem_we;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata = '0;

    logic [W-1:0] mem [0:1023];

    int cmp  = 0;
    int errs = 0;

    mem_port_arbiter #(.WIDTH(W), .STREAK_MAX(4)) dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ready (if_ready),
        .if_rdata (if_rdata),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_ready (ls_ready),
        .ls_rdata (ls_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[9:0]];
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge CLOCK);
    endtask

    task automatic test_reset;
        @(negedge CLOCK);
        @(negedge CLOCK);
        cmp++;
        if ({mem_en, mem_we, if_ready, ls_ready} !== 4'b0) begin
            $display("FAIL reset_ctrl: got %b want 0000", {mem_en, mem_we, if_ready, ls_ready});
            errs++;
        end
        cmp++;
        if ({mem_addr, mem_wdata, if_rdata, ls_rdata} !== '0) begin
            $display("FAIL reset_data: got %h %h %h %h want 0", mem_addr, mem_wdata, if_rdata, ls_rdata);
            errs++;
        end
        RESET = 1'b0;
        idle(2);
    endtask

    task automatic test_load;
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 32'h100;
        @(negedge CLOCK);
        cmp++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
            $display("FAIL load_access: got en=%b we=%b addr=%h want en=1 we=0 addr=100", mem_en, mem_we, mem_addr);
            errs++;
        end
        cmp++;
        if (ls_ready !== 1'b0) begin
            $display("FAIL load_early_ready: got %b want 0", ls_ready);
            errs++;
        end
        ls_addr = 32'h3F0;
        @(negedge CLOCK);
        cmp++;
        if ({ls_ready, if_ready, mem_en} !== 3'b100) begin
            $display("FAIL load_resp: got ls_ready=%b if_ready=%b en=%b want 1 0 0", ls_ready, if_ready, mem_en);
            errs++;
        end
        cmp++;
        if (ls_rdata !== 32'hDEADBEEF) begin
            $display("FAIL load_rdata: got %h want deadbeef", ls_rdata);
            errs++;
        end
        cmp++;
        if (mem_addr !== 32'h100) begin
            $display("FAIL load_addr_held: got %h want 100", mem_addr);
            errs++;
        end
        ls_req = 1'b0;
        @(negedge CLOCK);
        cmp++;
        if ({ls_ready, mem_en, ls_rdata} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin
            $display("FAIL load_hold: got ready=%b en=%b rdata=%h want 0 0 deadbeef", ls_ready, mem_en, ls_rdata);
            errs++;
        end
        idle(1);
    endtask

    task automatic test_store;
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 32'h20;
        ls_wdata = 32'h12345678;
        @(negedge CLOCK);
        cmp++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h20, 32'h12345678}) begin
            $display("FAIL store_access: got en=%b we=%b addr=%h data=%h want 1 1 20 12345678", mem_en, mem_we, mem_addr, mem_wdata);
            errs++;
        end
        ls_wdata = 32'h0;
        @(negedge CLOCK);
        cmp++;
        if (ls_ready !== 1'b1) begin
            $display("FAIL store_ready: got %b want 1", ls_ready);
            errs++;
        end
        ls_we = 1'b0;
        @(negedge CLOCK);
        cmp++;
        if ({ls_ready, mem_en} !== 2'b00) begin
            $display("FAIL no_regrant_in_resp: got ready=%b en=%b want 0 0", ls_ready, mem_en);
            errs++;
        end
        @(negedge CLOCK);
        cmp++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h20}) begin
            $display("FAIL reload_access: got en=%b we=%b addr=%h want 1 0 20", mem_en, mem_we, mem_addr);
            errs++;
        end
        @(negedge CLOCK);
        cmp++;
        if ({ls_ready, ls_rdata} !== {1'b1, 32'h12345678}) begin
            $display("FAIL reload_rdata: got ready=%b rdata=%h want 1 12345678", ls_ready, ls_rdata);
            errs++;
        end
        ls_req = 1'b0;
        idle(2);
    endtask

    task automatic test_contention;
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 32'h100;
        if_req  = 1'b1;
        if_addr = 32'h40;
        @(negedge CLOCK);
        cmp++;
        if (mem_addr !== 32'h100) begin
            $display("FAIL contention_ls_first: got addr=%h want 100", mem_addr);
            errs++;
        end
        @(negedge CLOCK);
        cmp++;
        if ({ls_ready, if_ready} !== 2'b10) begin
            $display("FAIL contention_ls_ready: got ls=%b if=%b want 1 0", ls_ready, if_ready);
            errs++;
        end
        ls_req = 1'b0;
        @(negedge CLOCK);
        @(negedge CLOCK);
        cmp++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h40}) begin
            $display("FAIL contention_if_access: got en=%b we=%b addr=%h want 1 0 40", mem_en, mem_we, mem_addr);
            errs++;
        end
        @(negedge CLOCK);
        cmp++;
        if ({if_ready, ls_ready, if_rdata} !== {1'b1, 1'b0, 32'h00000013}) begin
            $display("FAIL contention_if_resp: got if=%b ls=%b rdata=%h want 1 0 00000013", if_ready, ls_ready, if_rdata);
            errs++;
        end
        if_req = 1'b0;
        idle(2);
    endtask

    task automatic test_fairness;
        int ls_cnt   = 0;
        int if_cnt   = 0;
        int grants   = 0;
        int first_if = -1;
        int overlap  = 0;
        int exp_ls, exp_if, exp_first;
`ifdef ARB_FAIR_EN
        exp_ls = 8; exp_if = 2; exp_first = 4;
`else
        exp_ls = 10; exp_if = 0; exp_first = -1;
`endif
        ls_req  = 1'b1;
        ls_addr = 32'h80;
        if_req  = 1'b1;
        if_addr = 32'h40;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLOCK);
            if (if_ready && ls_ready) overlap++;
            if (ls_ready) begin
                ls_cnt++;
                grants++;
            end
            if (if_ready) begin
                if (first_if < 0) first_if = grants;
                if_cnt++;
                grants++;
            end
        end
        ls_req = 1'b0;
        if_req = 1'b0;
        cmp++;
        if (ls_cnt !== exp_ls) begin
            $display("FAIL fair_ls_count: got %0d want %0d", ls_cnt, exp_ls);
            errs++;
        end
        cmp++;
        if (if_cnt !== exp_if) begin
            $display("FAIL fair_if_count: got %0d want %0d", if_cnt, exp_if);
            errs++;
        end
        cmp++;
        if (first_if !== exp_first) begin
            $display("FAIL fair_first_if: got %0d want %0d", first_if, exp_first);
            errs++;
        end
        cmp++;
        if (overlap !== 0) begin
            $display("FAIL ready_overlap: got %0d want 0", overlap);
            errs++;
        end
        idle(3);
    endtask

    task automatic test_reset_mid_op;
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 32'h100;
        @(negedge CLOCK);
        cmp++;
        if (mem_en !== 1'b1) begin
            $display("FAIL midrst_access: got en=%b want 1", mem_en);
            errs++;
        end
        RESET   = 1'b1;
        ls_req  = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h40;
        #1;
        cmp++;
        if ({mem_en, mem_we, ls_ready, if_ready, mem_addr} !== '0) begin
            $display("FAIL midrst_clear: got en=%b we=%b ls=%b if=%b addr=%h want all 0", mem_en, mem_we, ls_ready, if_ready, mem_addr);
            errs++;
        end
        @(negedge CLOCK);
        cmp++;
        if ({ls_ready, if_ready, mem_en} !== 3'b000) begin
            $display("FAIL midrst_held: got ls=%b if=%b en=%b want 0 0 0", ls_ready, if_ready, mem_en);
            errs++;
        end
        RESET = 1'b0;
        @(negedge CLOCK);
        cmp++;
        if ({mem_en, mem_addr, if_ready, ls_ready} !== {1'b1, 32'h40, 1'b0, 1'b0}) begin
            $display("FAIL midrst_if_access: got en=%b addr=%h if=%b ls=%b want 1 40 0 0", mem_en, mem_addr, if_ready, ls_ready);
            errs++;
        end
        @(negedge CLOCK);
        cmp++;
        if ({if_ready, ls_ready, if_rdata} !== {1'b1, 1'b0, 32'h00000013}) begin
            $display("FAIL midrst_if_resp: got if=%b ls=%b rdata=%h want 1 0 00000013", if_ready, ls_ready, if_rdata);
            errs++;
        end
        if_req = 1'b0;
        idle(2);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h100] = 32'hDEADBEEF;
        mem[10'h040] = 32'h00000013;
        mem[10'h080] = 32'hCAFEF00D;
        test_reset();
        test_load();
        test_store();
        test_contention();
        test_fairness();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
